// File: rtl/lfsr_checker.sv
// ============================================================================
// lfsr_checker
// ----------------------------------------------------------------------------
// Receive-side partner of the LFSR generator. The checker takes a byte stream
// whose successive values are successive Fibonacci LFSR states. It seeds its
// own LFSR from the received data and confirms the seed over LOCK_CNT further
// bytes. After that it runs its LFSR freely (flywheel) and counts the bit
// errors between the received bytes and its own prediction.
//
// LFSR step: step(s) = {s[WIDTH-2:0], ^(s & taps)}. The register shifts left
// and the feedback bit enters at the LSB.
//
// Parameters
//   WIDTH       LFSR / data width in bits
//   CNT_W       width of err_count and bytes_checked (both saturate)
//   LOCK_CNT    consecutive matching bytes in VERIFY needed to lock
//   ERR_THRESH  consecutive errored bytes in LOCKED that force a resync
//   TAP_INIT    tap mask loaded at reset
//
// Ports
//   clock          in   1      single clock, rising edge
//   reset_n        in   1      asynchronous active-low reset
//   tapIn          in   WIDTH  tap mask, loaded when tapEn=1
//   tapEn          in   1      load tapIn into the tap register and reseed
//   start          in   1      clear the counters and reseed
//   in_valid       in   1      in carries a byte this cycle
//   in             in   WIDTH  received LFSR byte
//   locked         out  1      checker synchronised
//   err_flag       out  1      one-cycle pulse: the last compared byte had
//                              at least one bit error
//   err_count      out  CNT_W  accumulated bit errors, saturating
//   bytes_checked  out  CNT_W  bytes compared while locked, saturating
//
// Priority in each cycle: start > tapEn > in_valid.
// All outputs are registered. They reflect a byte on the edge after the byte
// is sampled.
//
// Build option
//   LFSR_CHECKER_RESYNC_EN  When defined, ERR_THRESH consecutive errored
//                           bytes in LOCKED make the checker drop lock and
//                           reseed from the last of those bytes. When
//                           undefined, LOCKED holds until start, tapEn or
//                           reset, and errors are only counted.
// ============================================================================
module lfsr_checker #(
    parameter int               WIDTH      = 8,
    parameter int               CNT_W      = 16,
    parameter int               LOCK_CNT   = 4,
    parameter int               ERR_THRESH = 3,
    parameter logic [WIDTH-1:0] TAP_INIT   = WIDTH'(8'hB8)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tapIn,
    input  logic             tapEn,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bytes_checked
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    // One counter serves two purposes. In VERIFY it counts matching bytes. In
    // LOCKED it counts consecutive errored bytes. Its width must therefore
    // cover the larger of the two limits.
    localparam int SEQ_MAX = (LOCK_CNT > ERR_THRESH) ? LOCK_CNT : ERR_THRESH;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int PC_W    = $clog2(WIDTH + 1);   // popcount of one byte
    localparam int SUM_W   = CNT_W + PC_W;        // err_count + popcount, no overflow

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,   // waiting for a non-zero byte to seed from
        ST_VERIFY = 2'd1,   // seeded, confirming LOCK_CNT successive states
        ST_LOCKED = 2'd2    // flywheeling and counting bit errors
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] t);
        return {s[WIDTH-2:0], ^(s & t)};
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   taps_q,     taps_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [SEQ_W-1:0]   seq_cnt_q,  seq_cnt_d;
    logic               locked_q,   locked_d;
    logic               err_flag_q, err_flag_d;
    logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0]   bytes_q,    bytes_d;

    // Compare path for a byte in LOCKED
    logic [PC_W-1:0]    bit_errs;
    logic [SUM_W-1:0]   err_sum;

    assign bit_errs = popcount(in ^ expected_q);
    assign err_sum  = SUM_W'(err_cnt_q) + SUM_W'(bit_errs);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments, so
    // every flop samples the values from before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SEED;
            taps_q     <= TAP_INIT;
            expected_q <= '0;
            seq_cnt_q  <= '0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            bytes_q    <= '0;
        end else begin
            state_q    <= state_d;
            taps_q     <= taps_d;
            expected_q <= expected_d;
            seq_cnt_q  <= seq_cnt_d;
            locked_q   <= locked_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            bytes_q    <= bytes_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block. Any path
    // that does not assign a variable then holds its value, and no latch is
    // inferred.
    always_comb begin
        state_d    = state_q;
        taps_d     = taps_q;
        expected_d = expected_q;
        seq_cnt_d  = seq_cnt_q;
        locked_d   = locked_q;
        err_flag_d = 1'b0;          // pulse: set only on a LOCKED compare
        err_cnt_d  = err_cnt_q;
        bytes_d    = bytes_q;

        if (start) begin
            err_cnt_d = '0;
            bytes_d   = '0;
            state_d   = ST_SEED;
            locked_d  = 1'b0;
            seq_cnt_d = '0;
        end else if (tapEn) begin
            taps_d    = tapIn;
            state_d   = ST_SEED;
            locked_d  = 1'b0;
            seq_cnt_d = '0;
        end else if (in_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    // All-zero is the LFSR lockup state and cannot seed
                    // anything, so a zero byte is ignored.
                    if (in != '0) begin
                        expected_d = lfsr_step(in, taps_q);
                        seq_cnt_d  = '0;
                        state_d    = ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    if (in == expected_q) begin
                        seq_cnt_d  = seq_cnt_q + SEQ_W'(1);
                        expected_d = lfsr_step(in, taps_q);
                        if (seq_cnt_q == SEQ_W'(LOCK_CNT - 1)) begin
                            state_d   = ST_LOCKED;
                            locked_d  = 1'b1;
                            seq_cnt_d = '0;   // becomes the error-run counter
                        end
                    end else begin
                        // Reseed from the byte that broke the run.
                        seq_cnt_d = '0;
                        if (in == '0) begin
                            state_d = ST_SEED;
                        end else begin
                            expected_d = lfsr_step(in, taps_q);
                        end
                    end
                end

                ST_LOCKED: begin
                    if (bytes_q != CNT_SAT) begin
                        bytes_d = bytes_q + CNT_W'(1);
                    end
                    if (err_sum > SUM_W'(CNT_SAT)) begin
                        err_cnt_d = CNT_SAT;
                    end else begin
                        err_cnt_d = err_sum[CNT_W-1:0];
                    end
                    err_flag_d = (bit_errs != '0);
                    // Flywheel: the prediction depends only on our own state.
                    expected_d = lfsr_step(expected_q, taps_q);
`ifdef LFSR_CHECKER_RESYNC_EN
                    if (bit_errs != '0) begin
                        if (seq_cnt_q == SEQ_W'(ERR_THRESH - 1)) begin
                            // The byte is already counted above. Now drop
                            // lock and reseed from it.
                            locked_d  = 1'b0;
                            seq_cnt_d = '0;
                            if (in == '0) begin
                                state_d = ST_SEED;
                            end else begin
                                expected_d = lfsr_step(in, taps_q);
                                state_d    = ST_VERIFY;
                            end
                        end else begin
                            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                        end
                    end else begin
                        seq_cnt_d = '0;
                    end
`else
                    // Without resync, lock is held until start, tapEn or
                    // reset.
`endif
                end

                default: begin
                    state_d  = ST_SEED;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign locked        = locked_q;
    assign err_flag      = err_flag_q;
    assign err_count     = err_cnt_q;
    assign bytes_checked = bytes_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ============================================================================
// tb_lfsr_checker
// ----------------------------------------------------------------------------
// Drives two checkers from the same inputs. The first uses CNT_W=16. The
// second uses CNT_W=4, so counter saturation shows up quickly. A per-byte
// reference model computes every expected output from the checker's rules:
// seed, confirm, flywheel, count. The model keeps raw unbounded totals and
// clips them to each counter's maximum only when comparing.
// ============================================================================
module tb_lfsr_checker;

    localparam int LOCK_CNT   = 4;
    localparam int ERR_THRESH = 3;

    // Model phases
    localparam int P_SEED   = 0;
    localparam int P_VERIFY = 1;
    localparam int P_LOCKED = 2;

    logic       clock;
    logic       reset_n;
    logic [7:0] tap_in;
    logic       tap_en;
    logic       start;
    logic       in_valid;
    logic [7:0] din;

    logic        locked_a, err_flag_a;
    logic [15:0] err_count_a, bytes_a;
    logic        locked_b, err_flag_b;
    logic [3:0]  err_count_b, bytes_b;

    int checks = 0;
    int errors = 0;

    lfsr_checker #(.WIDTH(8), .CNT_W(16), .LOCK_CNT(LOCK_CNT), .ERR_THRESH(ERR_THRESH)) dut (
        .clock(clock), .reset_n(reset_n), .tapIn(tap_in), .tapEn(tap_en),
        .start(start), .in_valid(in_valid), .in(din),
        .locked(locked_a), .err_flag(err_flag_a),
        .err_count(err_count_a), .bytes_checked(bytes_a)
    );

    lfsr_checker #(.WIDTH(8), .CNT_W(4), .LOCK_CNT(LOCK_CNT), .ERR_THRESH(ERR_THRESH)) dut_sat (
        .clock(clock), .reset_n(reset_n), .tapIn(tap_in), .tapEn(tap_en),
        .start(start), .in_valid(in_valid), .in(din),
        .locked(locked_b), .err_flag(err_flag_b),
        .err_count(err_count_b), .bytes_checked(bytes_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [7:0] m_taps;
    logic [7:0] m_expected;
    int         m_phase;
    int         m_matches;
    int         m_run;
    bit         m_locked;
    bit         m_flag;
    int         m_errs;     // raw bit-error total since the last clear
    int         m_bytes;    // raw count of bytes compared while locked

    function automatic logic [7:0] next_state(input logic [7:0] s, input logic [7:0] t);
        int fb;
        fb = $countones(s & t) % 2;
        return 8'((int'(s) * 2) % 256 + fb);
    endfunction

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_taps     = 8'hB8;
        m_expected = 8'h00;
        m_phase    = P_SEED;
        m_matches  = 0;
        m_run      = 0;
        m_locked   = 0;
        m_flag     = 0;
        m_errs     = 0;
        m_bytes    = 0;
    endtask

    task automatic model_reseed(input logic [7:0] d);
        m_matches = 0;
        if (d == 8'h00) begin
            m_phase = P_SEED;
        end else begin
            m_expected = next_state(d, m_taps);
            m_phase    = P_VERIFY;
        end
    endtask

    task automatic model_clock(input bit st, input bit te, input logic [7:0] ti,
                               input bit v, input logic [7:0] d);
        int e;
        m_flag = 0;
        if (st) begin
            m_errs = 0; m_bytes = 0; m_phase = P_SEED; m_locked = 0; m_run = 0;
        end else if (te) begin
            m_taps = ti; m_phase = P_SEED; m_locked = 0; m_run = 0;
        end else if (v) begin
            if (m_phase == P_SEED) begin
                if (d != 8'h00) model_reseed(d);
            end else if (m_phase == P_VERIFY) begin
                if (d == m_expected) begin
                    m_matches++;
                    m_expected = next_state(d, m_taps);
                    if (m_matches == LOCK_CNT) begin
                        m_phase  = P_LOCKED;
                        m_locked = 1;
                        m_run    = 0;
                    end
                end else begin
                    model_reseed(d);
                end
            end else begin
                e          = $countones(d ^ m_expected);
                m_bytes   += 1;
                m_errs    += e;
                m_flag     = (e != 0);
                m_expected = next_state(m_expected, m_taps);
`ifdef LFSR_CHECKER_RESYNC_EN
                if (e != 0) begin
                    m_run++;
                    if (m_run == ERR_THRESH) begin
                        m_run    = 0;
                        m_locked = 0;
                        model_reseed(d);
                    end
                end else begin
                    m_run = 0;
                end
`endif
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("locked",       32'(locked_a),    32'(m_locked));
        check("err_flag",     32'(err_flag_a),  32'(m_flag));
        check("err_count",    32'(err_count_a), 32'(clip(m_errs, 65535)));
        check("bytes",        32'(bytes_a),     32'(clip(m_bytes, 65535)));
        check("sat_locked",   32'(locked_b),    32'(m_locked));
        check("sat_err_flag", 32'(err_flag_b),  32'(m_flag));
        check("sat_err_count",32'(err_count_b), 32'(clip(m_errs, 15)));
        check("sat_bytes",    32'(bytes_b),     32'(clip(m_bytes, 15)));
    endtask

    // One clock with the given inputs, followed by the model update and checks.
    task automatic cycle(input bit st, input bit te, input logic [7:0] ti,
                         input bit v, input logic [7:0] d);
        start = st; tap_en = te; tap_in = ti; in_valid = v; din = d;
        @(posedge clock);
        #1;
        model_clock(st, te, ti, v, d);
        check_all();
        start = 0; tap_en = 0; in_valid = 0;
    endtask

    task automatic send(input logic [7:0] d);
        cycle(0, 0, 8'h00, 1, d);
    endtask

    task automatic idle();
        cycle(0, 0, 8'h00, 0, 8'h00);
    endtask

    // Asserts reset mid-cycle. The outputs must clear before any clock edge.
    task automatic async_reset();
        #2;
        reset_n = 0;
        #1;
        check("rst_locked",   32'(locked_a),    32'd0);
        check("rst_err_flag", 32'(err_flag_a),  32'd0);
        check("rst_err_cnt",  32'(err_count_a), 32'd0);
        check("rst_bytes",    32'(bytes_a),     32'd0);
        check("rst_sat_cnt",  32'(err_count_b), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    // Restarts the checker and locks it onto the stream FF,FE,FC,F8,F0
    // (taps B8).
    task automatic lock_b8();
        cycle(1, 0, 8'h00, 0, 8'h00);
        send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8); send(8'hF0);
    endtask

    logic [7:0] g;        // stimulus generator state
    logic [7:0] g_taps;   // taps the stimulus generator runs with

    initial begin
        reset_n = 0; tap_in = 0; tap_en = 0; start = 0; in_valid = 0; din = 0;
        model_reset();
        #12;
        check("init_locked", 32'(locked_a),    32'd0);
        check("init_count",  32'(err_count_a), 32'd0);
        @(negedge clock);
        reset_n = 1;
        idle();

        // --- 1: seed and lock on FF,FE,FC,F8,F0
        send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8);
        check("t1_not_yet", 32'(locked_a), 32'd0);
        send(8'hF0);
        check("t1_locked", 32'(locked_a), 32'd1);
        check("t1_bytes",  32'(bytes_a),  32'd0);

        // --- 2: E1 clean, then C3 against expected C2 (one bit error)
        send(8'hE1);
        send(8'hC3);
        check("t2_bytes",  32'(bytes_a),     32'd2);
        check("t2_errs",   32'(err_count_a), 32'd1);
        check("t2_flag",   32'(err_flag_a),  32'd1);
        idle();
        check("t2_flag_clr", 32'(err_flag_a), 32'd0);
        check("t2_locked",   32'(locked_a),   32'd1);

        // --- 3: zeros are ignored in SEED, then a VERIFY mismatch reseeds
        cycle(1, 0, 8'h00, 0, 8'h00);
        send(8'h00); send(8'h00);
        send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8); send(8'hF0);
        check("t3_locked", 32'(locked_a), 32'd1);
        cycle(1, 0, 8'h00, 0, 8'h00);
        send(8'hFF); send(8'h12);
        check("t3_reseed", 32'(locked_a), 32'd0);

        // --- 4: six inverted bytes saturate the 4-bit counter
        lock_b8();
        g = 8'hE1;
        for (int i = 0; i < 6; i++) begin
            send(~g);
            g = next_state(g, 8'hB8);
        end
        check("t4_sat", 32'(err_count_b), 32'd15);

        // --- 5: three single-bit-errored bytes in a row while locked
        lock_b8();
        g = 8'hE1;
        for (int i = 0; i < 3; i++) begin
            send(g ^ 8'h01);
            g = next_state(g, 8'hB8);
        end
        check("t5_errs", 32'(err_count_a), 32'd3);
`ifdef LFSR_CHECKER_RESYNC_EN
        check("t5_locked", 32'(locked_a), 32'd0);
`else
        check("t5_locked", 32'(locked_a), 32'd1);
`endif

        // --- 6: tapEn while locked, start, then asynchronous reset
        lock_b8();
        send(8'hE0);   // one bit error, so the counters are non-zero
        cycle(0, 1, 8'h8E, 0, 8'h00);
        check("t6_tap_unlock", 32'(locked_a),    32'd0);
        check("t6_tap_keep",   32'(err_count_a), 32'd1);
        check("t6_tap_bytes",  32'(bytes_a),     32'd1);
        cycle(1, 0, 8'h00, 0, 8'h00);
        check("t6_start_clr",  32'(bytes_a), 32'd0);
        // Lock onto the new taps, then reset mid-stream.
        g = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            send(g);
            g = next_state(g, 8'h8E);
        end
        check("t6_locked_8e", 32'(locked_a), 32'd1);
        async_reset();
        idle();

        // --- Randomised stream
        g      = 8'h01 + 8'($urandom_range(0, 254));
        g_taps = 8'hB8;
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) begin
                cycle(1, 0, 8'h00, 0, 8'h00);
            end else if (r < 10) begin
                logic [7:0] t;
                case ($urandom_range(0, 2))
                    0:       t = 8'hB8;
                    1:       t = 8'h8E;
                    default: t = 8'($urandom_range(1, 255));
                endcase
                g_taps = t;
                cycle(0, 1, t, 0, 8'h00);
            end else if (r < 12) begin
                async_reset();
                g_taps = 8'hB8;
            end else if (r < 250) begin
                idle();
            end else begin
                int k;
                k = $urandom_range(0, 99);
                if (k < 70) begin
                    send(g);
                    g = next_state(g, g_taps);
                end else if (k < 82) begin
                    send(g ^ 8'($urandom_range(1, 255)));
                    g = next_state(g, g_taps);
                end else if (k < 87) begin
                    send(8'h00);
                end else begin
                    g = 8'($urandom_range(1, 255));
                    send(g);
                    g = next_state(g, g_taps);
                end
                if (g == 8'h00) g = 8'($urandom_range(1, 255));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
